// File: rtl/rf_pulse_gen.sv
// rf_pulse_gen: burst transmitter for the fsm_sync receiver path.
// A burst is frame_count frames of frame_len cycles. Each frame carries one
// rfin pulse at [pulse_pos, pulse_pos+pulse_width) and one sh_en strobe at
// sh_pos. Config is shadowed on an accepted start. One LOAD cycle separates
// the start edge from the first frame cycle. All outputs are registered.
module rf_pulse_gen #(
  parameter int CNT_W = 16,
  parameter int FRM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] frame_len,
  input  logic [CNT_W-1:0] pulse_pos,
  input  logic [CNT_W-1:0] pulse_width,
  input  logic [CNT_W-1:0] sh_pos,
  input  logic [FRM_W-1:0] frame_count,
  output logic             rfin,
  output logic             sh_en,
  output logic [FRM_W-1:0] frame_idx,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_PRE  = 3'd2,
    S_HIGH = 3'd3,
    S_POST = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FRM_W-1:0] frame_idx_q, frame_idx_d;
  logic [CNT_W-1:0] len_q, pos_q, wid_q, sh_q;
  logic [FRM_W-1:0] frames_q;
  logic             cfg_err_q, cfg_err_d;
  logic             rfin_q, sh_en_q, busy_q, done_q;
  logic             cfg_load_s, cfg_bad_s, in_frame_s;
  logic [CNT_W:0]   cfg_end_s;

  // Which window of the frame a given cycle index falls into.
  function automatic state_t region(input logic [CNT_W-1:0] k,
                                    input logic [CNT_W-1:0] pos,
                                    input logic [CNT_W-1:0] wid);
    logic [CNT_W:0] end_v;
    end_v = {1'b0, pos} + {1'b0, wid};
    if ({1'b0, k} < {1'b0, pos}) begin
      return S_PRE;
    end else if ({1'b0, k} < end_v) begin
      return S_HIGH;
    end else begin
      return S_POST;
    end
  endfunction

  // Start validation on the raw config inputs; the sum is one bit wider so it cannot wrap.
  always_comb begin
    cfg_end_s = {1'b0, pulse_pos} + {1'b0, pulse_width};
    cfg_bad_s = (frame_len == CNT_W'(0)) || (pulse_width == CNT_W'(0)) ||
                (frame_count == FRM_W'(0)) || (cfg_end_s > {1'b0, frame_len}) ||
                (sh_pos >= frame_len);
  end

  // Next-state, counter, frame index and error-flag logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_idx_d = frame_idx_q;
    cfg_err_d   = cfg_err_q;
    cfg_load_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (start && cfg_bad_s) begin
          cfg_err_d = 1'b1;
        end else if (start) begin
          cfg_err_d   = 1'b0;
          cfg_load_s  = 1'b1;
          cnt_d       = CNT_W'(0);
          frame_idx_d = FRM_W'(0);
          state_d     = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = CNT_W'(0);
          state_d = region(CNT_W'(0), pos_q, wid_q);
        end
      end
      S_PRE, S_HIGH, S_POST: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == len_q - CNT_W'(1)) begin
          if (frame_idx_q == frames_q - FRM_W'(1)) begin
            state_d = S_DONE;
          end else begin
            cnt_d       = CNT_W'(0);
            frame_idx_d = frame_idx_q + FRM_W'(1);
            state_d     = region(CNT_W'(0), pos_q, wid_q);
          end
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = region(cnt_q + CNT_W'(1), pos_q, wid_q);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    in_frame_s = (state_d == S_PRE) || (state_d == S_HIGH) || (state_d == S_POST);
  end

  // State, counter, shadow config and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= CNT_W'(0);
      frame_idx_q <= FRM_W'(0);
      len_q       <= CNT_W'(0);
      pos_q       <= CNT_W'(0);
      wid_q       <= CNT_W'(0);
      sh_q        <= CNT_W'(0);
      frames_q    <= FRM_W'(0);
      cfg_err_q   <= 1'b0;
      rfin_q      <= 1'b0;
      sh_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_idx_q <= frame_idx_d;
      cfg_err_q   <= cfg_err_d;
      rfin_q      <= (state_d == S_HIGH);
      sh_en_q     <= in_frame_s && (cnt_d == sh_q);
      busy_q      <= in_frame_s;
      done_q      <= (state_d == S_DONE);
      if (cfg_load_s) begin
        len_q    <= frame_len;
        pos_q    <= pulse_pos;
        wid_q    <= pulse_width;
        sh_q     <= sh_pos;
        frames_q <= frame_count;
      end else begin
        len_q    <= len_q;
        pos_q    <= pos_q;
        wid_q    <= wid_q;
        sh_q     <= sh_q;
        frames_q <= frames_q;
      end
    end
  end

  assign rfin      = rfin_q;
  assign sh_en     = sh_en_q;
  assign frame_idx = frame_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;

endmodule
